// File: rtl/shift_right_unit_if.sv
// Handshake/bus bundle for shift_right_unit.
//   master: drives start/op/num1/num2/carry_in, observes busy/done/result/flags
//   slave : the shift unit itself
interface shift_right_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             n_flag;
    logic             z_flag;
    logic             c_flag;

    modport master (
        output start, op, num1, num2, carry_in,
        input  busy, done, result, n_flag, z_flag, c_flag
    );

    modport slave (
        input  start, op, num1, num2, carry_in,
        output busy, done, result, n_flag, z_flag, c_flag
    );
endinterface

// File: rtl/shift_right_unit.sv
// Multi-cycle LSR/ASR/ROR unit, one bit per cycle, with Thumb N/Z/C flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   sru   : slave side of shift_right_unit_if (start/op/num1/num2/carry_in in,
//           busy/done/result/n_flag/z_flag/c_flag out, all outputs registered)
module shift_right_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_right_unit_if.slave  sru
);
    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = SH_W + 1;
    localparam int unsigned AMT_W = 8;

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             over_q, over_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             c_q, c_d;

    logic [AMT_W-1:0] amt_c;
    logic [CNT_W-1:0] cnt_init_c;
    logic [WIDTH-1:0] shifted_c;
    logic             unused_num2;

    assign amt_c       = sru.num2[AMT_W-1:0];
    assign unused_num2 = ^sru.num2[WIDTH-1:AMT_W];

    // Effective bit count: linear shifts saturate at WIDTH, rotates wrap.
    always_comb begin
        cnt_init_c = '0;
        case (sru.op)
            OP_LSR, OP_ASR: begin
                if (amt_c >= AMT_W'(WIDTH)) cnt_init_c = CNT_W'(WIDTH);
                else                        cnt_init_c = CNT_W'(amt_c);
            end
            OP_ROR:  cnt_init_c = CNT_W'(amt_c[SH_W-1:0]);
            default: cnt_init_c = '0;
        endcase
    end

    // One-bit step of the latched operation.
    always_comb begin
        shifted_c = acc_q;
        case (op_q)
            OP_LSR:  shifted_c = {1'b0,             acc_q[WIDTH-1:1]};
            OP_ASR:  shifted_c = {acc_q[WIDTH-1],   acc_q[WIDTH-1:1]};
            OP_ROR:  shifted_c = {acc_q[0],         acc_q[WIDTH-1:1]};
            default: shifted_c = acc_q;
        endcase
    end

    // Next-state and output logic; result/flags are loaded on entry to DONE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        over_d   = over_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        c_d      = c_q;

        case (state_q)
            S_IDLE: begin
                if (sru.start) begin
                    busy_d = 1'b1;
                    op_d   = sru.op;
                    acc_d  = sru.num1;
                    cnt_d  = cnt_init_c;
                    // LSR past the width shifts out only zeros, so C ends up 0.
                    over_d = (sru.op == OP_LSR) && (amt_c > AMT_W'(WIDTH));
                    if (cnt_init_c == '0) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = sru.num1;
                        // ROR by a non-zero multiple of WIDTH reports the MSB.
                        if ((sru.op == OP_ROR) && (amt_c != '0)) c_d = sru.num1[WIDTH-1];
                        else                                     c_d = sru.carry_in;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = shifted_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = shifted_c;
                    c_d      = over_q ? 1'b0 : acc_q[0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        n_d = result_d[WIDTH-1];
        z_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            over_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            over_q   <= over_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            c_q      <= c_d;
        end
    end

    assign sru.busy   = busy_q;
    assign sru.done   = done_q;
    assign sru.result = result_q;
    assign sru.n_flag = n_q;
    assign sru.z_flag = z_q;
    assign sru.c_flag = c_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed bench for shift_right_unit: vector table plus handshake/reset sequences.
module tb_shift_right_unit;
    localparam int unsigned WIDTH = 32;
    localparam int          MAX_WAIT = 60;

    logic clk;
    logic rst_n;

    shift_right_unit_if #(.WIDTH(WIDTH)) sru_bus ();

    shift_right_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sru   (sru_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] num1;
        logic [31:0] num2;
        logic        cin;
        logic [31:0] res;
        logic        c;
        logic        n;
        logic        z;
        int          lat;
    } vec_t;

    int tests;
    int fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request for a single cycle; returns #1 after the accept edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] n1,
                          input logic [31:0] n2, input logic cin);
        sru_bus.start    = 1'b1;
        sru_bus.op       = op;
        sru_bus.num1     = n1;
        sru_bus.num2     = n2;
        sru_bus.carry_in = cin;
        @(posedge clk);
        #1;
        sru_bus.start    = 1'b0;
        sru_bus.op       = 2'($urandom);
        sru_bus.num1     = $urandom;
        sru_bus.num2     = $urandom;
        sru_bus.carry_in = 1'($urandom);
    endtask

    // Count cycles until done; optionally pulse a competing start in cycle inj.
    // Returns at the falling edge of the done cycle.
    task automatic wait_done(input int inj, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < MAX_WAIT) begin
            lat++;
            if (inj != 0) begin
                if (lat == inj) begin
                    sru_bus.start    = 1'b1;
                    sru_bus.op       = 2'b01;
                    sru_bus.num1     = 32'hFFFF_FFFF;
                    sru_bus.num2     = 32'd1;
                    sru_bus.carry_in = 1'b0;
                end else begin
                    sru_bus.start = 1'b0;
                end
            end
            @(negedge clk);
            if (sru_bus.done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        sru_bus.start = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [31:0] res,
                                input logic c, input logic n, input logic z);
        check({name, " result"}, sru_bus.result, res);
        check({name, " C"}, 32'(sru_bus.c_flag), 32'(c));
        check({name, " N"}, 32'(sru_bus.n_flag), 32'(n));
        check({name, " Z"}, 32'(sru_bus.z_flag), 32'(z));
    endtask

    // Cycle after done: pulse must be gone, unit idle, result held.
    task automatic check_after_done(input string name, input logic [31:0] res);
        @(posedge clk);
        #1;
        check({name, " done pulse"}, 32'(sru_bus.done), 32'd0);
        check({name, " busy low"}, 32'(sru_bus.busy), 32'd0);
        check({name, " held"}, sru_bus.result, res);
    endtask

    vec_t vecs[14];

    initial begin
        int lat;
        bit ok;

        tests = 0;
        fails = 0;

        vecs[0]  = '{2'b00, 32'h8000_0001, 32'h0000_0001, 1'b0, 32'h4000_0000, 1'b1, 1'b0, 1'b0, 2};
        vecs[1]  = '{2'b01, 32'h8000_0000, 32'h0000_0028, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 33};
        vecs[2]  = '{2'b10, 32'h0000_0001, 32'h0000_0021, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 2};
        vecs[3]  = '{2'b10, 32'h8000_0001, 32'h0000_0020, 1'b0, 32'h8000_0001, 1'b1, 1'b1, 1'b0, 1};
        vecs[4]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0020, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 33};
        vecs[5]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0021, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 33};
        vecs[6]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0100, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1};
        vecs[7]  = '{2'b11, 32'h1234_5678, 32'h0000_0005, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{2'b01, 32'h7FFF_FFF0, 32'h0000_0004, 1'b1, 32'h07FF_FFFF, 1'b0, 1'b0, 1'b0, 5};
        vecs[9]  = '{2'b10, 32'h0000_00F1, 32'h0000_0004, 1'b1, 32'h1000_000F, 1'b0, 1'b0, 1'b0, 5};
        vecs[10] = '{2'b00, 32'h0000_0010, 32'h0000_0004, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 5};
        vecs[11] = '{2'b01, 32'h8000_0000, 32'h0000_001F, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32};
        vecs[12] = '{2'b00, 32'h0000_0003, 32'h0000_0002, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 3};
        vecs[13] = '{2'b01, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1};

        sru_bus.start    = 1'b0;
        sru_bus.op       = 2'b00;
        sru_bus.num1     = '0;
        sru_bus.num2     = '0;
        sru_bus.carry_in = 1'b0;
        rst_n            = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(sru_bus.busy), 32'd0);
        check("reset done", 32'(sru_bus.done), 32'd0);
        check_result("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back: each request issued in the cycle right after done.
        for (int i = 0; i < 14; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            launch(vecs[i].op, vecs[i].num1, vecs[i].num2, vecs[i].cin);
            check({nm, " busy"}, 32'(sru_bus.busy), 32'd1);
            wait_done(0, lat, ok);
            check({nm, " done seen"}, 32'(ok), 32'd1);
            check({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
            check_result(nm, vecs[i].res, vecs[i].c, vecs[i].n, vecs[i].z);
            check_after_done(nm, vecs[i].res);
        end

        // Competing start mid-shift is ignored.
        launch(2'b00, 32'h8000_0080, 32'd8, 1'b0);
        wait_done(3, lat, ok);
        check("midstart done seen", 32'(ok), 32'd1);
        check("midstart latency", 32'(lat), 32'd9);
        check_result("midstart", 32'h0080_0000, 1'b1, 1'b0, 1'b0);
        check_after_done("midstart", 32'h0080_0000);

        // Start in the cycle after done is accepted.
        launch(2'b10, 32'h0000_0001, 32'd1, 1'b0);
        check("b2b busy", 32'(sru_bus.busy), 32'd1);
        wait_done(0, lat, ok);
        check("b2b latency", 32'(lat), 32'd2);
        check_result("b2b", 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        check_after_done("b2b", 32'h8000_0000);

        // Reset during a 20-bit LSR discards it.
        launch(2'b00, 32'hFFFF_0000, 32'd20, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", 32'(sru_bus.busy), 32'd0);
        check("async rst done", 32'(sru_bus.done), 32'd0);
        check_result("async rst", 32'h0, 1'b0, 1'b0, 1'b0);
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (sru_bus.done) saw_done = 1'b1;
            end
            rst_n = 1'b1;
            repeat (25) begin
                @(negedge clk);
                if (sru_bus.done) saw_done = 1'b1;
            end
            check("discarded op no done", 32'(saw_done), 32'd0);
        end
        @(posedge clk);
        #1;
        launch(2'b00, 32'h0000_0010, 32'd4, 1'b1);
        wait_done(0, lat, ok);
        check("post-reset latency", 32'(lat), 32'd5);
        check_result("post-reset", 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
